uart_cmd_ctrl: RTL and testbench

//  Command controller between the UART receiver and the switch-input/FND-display logic.
//  - Buffers received bytes in a small FIFO and decodes single-character ASCII commands.
//  - Arbitrates UART commands against debounced button pulses to drive run/mode/clear controls.
//  - Optionally sequences a UART transmitter to send a one-byte ACK or NAK per command.

---
 rtl/uart_cmd_ctrl_pkg.sv | 44 ++++
 rtl/uart_cmd_ctrl_cmd_fifo.sv | 57 +++++
 rtl/uart_cmd_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: FSM states, ASCII constants and the
// command decoder.
package uart_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StExec    = 2'd1,
    StAck     = 2'd2,
    StAckHold = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CmdIgnore  = 3'd0,
    CmdRun     = 3'd1,
    CmdClear   = 3'd2,
    CmdMode    = 3'd3,
    CmdInvalid = 3'd4
  } cmd_e;

  localparam logic [7:0] AsciiR   = 8'h52;
  localparam logic [7:0] AsciiC   = 8'h43;
  localparam logic [7:0] AsciiM   = 8'h4D;
  localparam logic [7:0] AsciiCr  = 8'h0D;
  localparam logic [7:0] AsciiLf  = 8'h0A;
  localparam logic [7:0] AsciiNak = 8'h3F;
  localparam logic [7:0] CaseMask = 8'hDF;

  // CR/LF are matched on the raw byte; letters are matched after folding to upper case.
  function automatic cmd_e decode_cmd(input logic [7:0] b);
    cmd_e c;
    if (b == AsciiCr || b == AsciiLf) begin
      c = CmdIgnore;
    end else begin
      case (b & CaseMask)
        AsciiR:  c = CmdRun;
        AsciiC:  c = CmdClear;
        AsciiM:  c = CmdMode;
        default: c = CmdInvalid;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_cmd_fifo.sv
// Small synchronous byte FIFO with asynchronous active-high reset. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_cmd_ctrl_cmd_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam logic [FIFO_AW:0] CountFull = FIFO_DEPTH[FIFO_AW:0];

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers are exactly FIFO_AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: buffers RX bytes, decodes R/C/M commands, arbitrates against button
// pulses and, when UART_ACK_EN is defined, sends a one-byte ACK/NAK per command.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  input  logic       btn_run_i,
  input  logic       btn_clear_i,
  input  logic       btn_mode_i,
  input  logic       tx_busy_i,
  output logic       run_o,
  output logic       mode_o,
  output logic       clear_o,
  output logic       overflow_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o
);

  state_e     state_q;
  logic [7:0] cmd_q;
  logic       run_q;
  logic       mode_q;
  logic       clear_q;
  logic       overflow_q;

  logic       btn_any;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       ovf_event;
  cmd_e       cmd;

  assign btn_any   = btn_run_i | btn_clear_i | btn_mode_i;
  // Any button pulse holds off the UART path so the two never act in the same cycle.
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty && !btn_any;
  assign ovf_event = rx_done_i && fifo_full && !fifo_pop;
  assign cmd       = decode_cmd(cmd_q);

  uart_cmd_ctrl_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_done_i),
    .pop_i   (fifo_pop),
    .din_i   (rx_data_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef UART_ACK_EN
  logic       tx_start_q;
  logic [7:0] tx_data_q;

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
`else
  logic unused_tx_busy;

  assign unused_tx_busy = tx_busy_i;
  assign tx_start_o     = 1'b0;
  assign tx_data_o      = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      run_q      <= 1'b0;
      mode_q     <= 1'b0;
      clear_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_ACK_EN
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
`endif
    end else begin
      run_q   <= run_q ^ btn_run_i;
      mode_q  <= mode_q ^ btn_mode_i;
      clear_q <= btn_clear_i;
`ifdef UART_ACK_EN
      tx_start_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (fifo_pop) begin
            cmd_q   <= fifo_dout;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (!btn_any) begin
            unique case (cmd)
              CmdRun:   run_q  <= ~run_q;
              CmdMode:  mode_q <= ~mode_q;
              CmdClear: begin
                clear_q    <= 1'b1;
                overflow_q <= 1'b0;
              end
              default: ;
            endcase
`ifdef UART_ACK_EN
            state_q <= (cmd == CmdIgnore) ? StIdle : StAck;
`else
            state_q <= StIdle;
`endif
          end
        end
`ifdef UART_ACK_EN
        StAck: begin
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= (cmd == CmdInvalid) ? AsciiNak : (cmd_q & CaseMask);
            state_q    <= StAckHold;
          end
        end
        StAckHold: state_q <= StIdle;
`endif
        default: state_q <= StIdle;
      endcase
      // A dropped byte wins over a 'C' clearing the flag in the same cycle.
      if (ovf_event) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign run_o      = run_q;
  assign mode_o     = mode_q;
  assign clear_o    = clear_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: button vector table, directed command sequences and
// randomized traffic against a queue-based reference model. Follows UART_ACK_EN like the RTL.
module tb_uart_cmd_ctrl;

`ifdef UART_ACK_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif
  localparam int Depth = 4;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       btn_run;
  logic       btn_clear;
  logic       btn_mode;
  logic       tx_busy;
  logic       run_o;
  logic       mode_o;
  logic       clear_o;
  logic       overflow_o;
  logic       tx_start_o;
  logic [7:0] tx_data_o;

  int n_checks;
  int n_errors;

  uart_cmd_ctrl #(
    .FIFO_DEPTH (Depth),
    .FIFO_AW    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data_i   (rx_data),
    .rx_done_i   (rx_done),
    .btn_run_i   (btn_run),
    .btn_clear_i (btn_clear),
    .btn_mode_i  (btn_mode),
    .tx_busy_i   (tx_busy),
    .run_o       (run_o),
    .mode_o      (mode_o),
    .clear_o     (clear_o),
    .overflow_o  (overflow_o),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: byte queue plus the command currently in flight and its phase
  // (0 waiting, 1 acting, 2 acknowledging, 3 settling).
  logic [7:0] mq[$];
  logic [7:0] m_cmd;
  int         m_phase;
  logic       m_run, m_mode, m_clear, m_ovf, m_txs;
  logic [7:0] m_txd;

  task automatic model_reset();
    mq.delete();
    m_cmd = 8'h00; m_phase = 0;
    m_run = 0; m_mode = 0; m_clear = 0; m_ovf = 0; m_txs = 0; m_txd = 8'h00;
  endtask

  task automatic model_update();
    logic btn, pop, act, ign, valid, drop, do_r, do_c, do_m;
    logic [7:0] up;
    if (reset) begin
      model_reset();
      return;
    end
    btn   = btn_run || btn_clear || btn_mode;
    pop   = (m_phase == 0) && (mq.size() != 0) && !btn;
    act   = (m_phase == 1) && !btn;
    up    = m_cmd & 8'hDF;
    ign   = (m_cmd == 8'h0D) || (m_cmd == 8'h0A);
    valid = !ign && (up == 8'h52 || up == 8'h43 || up == 8'h4D);
    drop  = rx_done && (mq.size() == Depth) && !pop;
    do_r  = act && valid && up == 8'h52;
    do_c  = act && valid && up == 8'h43;
    do_m  = act && valid && up == 8'h4D;
    m_run   = m_run ^ btn_run ^ do_r;
    m_mode  = m_mode ^ btn_mode ^ do_m;
    m_clear = btn_clear || do_c;
    if (do_c) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    m_txs = 1'b0;
    case (m_phase)
      0: if (pop) begin m_cmd = mq.pop_front(); m_phase = 1; end
      1: if (!btn) m_phase = (ign || !AckEn) ? 0 : 2;
      2: if (!tx_busy) begin m_txs = 1'b1; m_txd = valid ? up : 8'h3F; m_phase = 3; end
      default: m_phase = 0;
    endcase
    if (rx_done && !drop) mq.push_back(rx_data);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    chk("m_run", run_o, m_run);
    chk("m_mode", mode_o, m_mode);
    chk("m_clear", clear_o, m_clear);
    chk("m_overflow", overflow_o, m_ovf);
    chk("m_tx_start", tx_start_o, m_txs);
    chk("m_tx_data", tx_data_o, m_txd);
    rx_done = 0; btn_run = 0; btn_clear = 0; btn_mode = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asserted away from the clock edge so the asynchronous clear is observed mid-cycle.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    rx_done = 0; btn_run = 0; btn_clear = 0; btn_mode = 0;
    #1;
    chk("rst_run", run_o, 0);
    chk("rst_mode", mode_o, 0);
    chk("rst_clear", clear_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_tx_start", tx_start_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic br, bc, bm;
    logic run, mode, clear;
  } btn_vec_t;

  btn_vec_t   vecs[8];
  logic [7:0] ovf_bytes[5];
  logic [7:0] tx_seen[$];
  logic [7:0] tx_exp[5];
  int         busy_cnt;

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; rx_data = 8'h00; rx_done = 0;
    btn_run = 0; btn_clear = 0; btn_mode = 0; tx_busy = 0;
    model_reset();

    vecs[0] = '{1, 0, 0, 1, 0, 0};
    vecs[1] = '{0, 0, 1, 1, 1, 0};
    vecs[2] = '{0, 1, 0, 1, 1, 1};
    vecs[3] = '{0, 0, 0, 1, 1, 0};
    vecs[4] = '{1, 0, 1, 0, 0, 0};
    vecs[5] = '{1, 1, 1, 1, 1, 1};
    vecs[6] = '{0, 0, 1, 1, 0, 0};
    vecs[7] = '{1, 1, 0, 0, 0, 1};
    ovf_bytes = '{8'h4D, 8'h52, 8'h58, 8'h6D, 8'h43};
    tx_exp    = '{8'h4D, 8'h4D, 8'h52, 8'h3F, 8'h4D};

    // Button table: each row is one cycle, expectations are cumulative from reset.
    apply_reset();
    foreach (vecs[i]) begin
      btn_run = vecs[i].br; btn_clear = vecs[i].bc; btn_mode = vecs[i].bm;
      tick();
      chk("tbl_run", run_o, vecs[i].run);
      chk("tbl_mode", mode_o, vecs[i].mode);
      chk("tbl_clear", clear_o, vecs[i].clear);
    end

    // Lower-case 'r': run toggles two edges after rx_done is sampled, ACK one edge later.
    apply_reset();
    send(8'h72);
    chk("t1_run_e0", run_o, 0);
    tick();
    chk("t1_run_e1", run_o, 0);
    tick();
    chk("t1_run_e2", run_o, 1);
    tick();
`ifdef UART_ACK_EN
    chk("t1_tx_start_e3", tx_start_o, 1);
    chk("t1_tx_data_e3", tx_data_o, 8'h52);
    tick();
    chk("t1_tx_start_e4", tx_start_o, 0);
    chk("t1_tx_data_hold", tx_data_o, 8'h52);
`else
    chk("t1_tx_start_off", tx_start_o, 0);
`endif
    idle(2);

    // Invalid 'X': no control change, NAK.
    send(8'h58);
    tick(); tick();
    chk("t2_run", run_o, 1);
    chk("t2_mode", mode_o, 0);
    chk("t2_clear", clear_o, 0);
    tick();
`ifdef UART_ACK_EN
    chk("t2_tx_start", tx_start_o, 1);
    chk("t2_tx_data", tx_data_o, 8'h3F);
`endif
    idle(3);

    // Overflow, in-order drain, then 'C' clears the flag.
    apply_reset();
`ifdef UART_ACK_EN
    tx_busy = 1'b1;
    send(8'h4D);
    idle(4);
    foreach (ovf_bytes[i]) send(ovf_bytes[i]);
`else
    for (int i = 0; i < 12; i++) send(ovf_bytes[i % 4]);
`endif
    chk("t3_overflow_set", overflow_o, 1);
    tx_busy = 1'b0;
    tx_seen.delete();
    for (int i = 0; i < 200 && !(mq.size() == 0 && m_phase == 0); i++) begin
      tick();
      if (tx_start_o) tx_seen.push_back(tx_data_o);
    end
    chk("t3_overflow_sticky", overflow_o, 1);
`ifdef UART_ACK_EN
    chk("t3_tx_count", tx_seen.size(), 5);
    foreach (tx_exp[i]) begin
      if (i < tx_seen.size()) chk("t3_tx_order", tx_seen[i], tx_exp[i]);
    end
`endif
    idle(2);
    send(8'h43);
    tick(); tick();
    chk("t3_clear_pulse", clear_o, 1);
    chk("t3_overflow_cleared", overflow_o, 0);
    idle(4);

    // Button in the same cycle as EXEC: button first, UART one cycle later.
    apply_reset();
    send(8'h4D);
    tick();
    btn_mode = 1'b1;
    tick();
    chk("t4_mode_btn", mode_o, 1);
    tick();
    chk("t4_mode_uart", mode_o, 0);
`ifdef UART_ACK_EN
    tick();
    chk("t4_tx_start", tx_start_o, 1);
    chk("t4_tx_data", tx_data_o, 8'h4D);
`endif
    idle(3);

    // CR followed by 'R': CR is dropped silently, 'R' keeps its short path.
    apply_reset();
    send(8'h0D);
    send(8'h52);
    chk("t5_tx_e1", tx_start_o, 0);
    tick();
    chk("t5_run_e2", run_o, 0);
    chk("t5_tx_e2", tx_start_o, 0);
    tick();
    chk("t5_run_e3", run_o, 0);
    tick();
    chk("t5_run_e4", run_o, 1);
    idle(3);
    send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_lf_no_tx", tx_start_o, 0);
    end

    // Reset mid-command with bytes still queued; the next 'R' behaves as from cold.
    apply_reset();
    tx_busy = 1'b1;
    send(8'h52);
    send(8'h4D);
    send(8'h52);
    chk("t6_run_before", run_o, 1);
    apply_reset();
    tx_busy = 1'b0;
    send(8'h52);
    tick(); tick();
    chk("t6_run_after", run_o, 1);
    tick();
`ifdef UART_ACK_EN
    chk("t6_tx_start", tx_start_o, 1);
    chk("t6_tx_data", tx_data_o, 8'h52);
`endif
    idle(8);
    chk("t6_mode_untouched", mode_o, 0);
    chk("t6_run_stable", run_o, 1);

    // Randomized traffic against the model.
    apply_reset();
    busy_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      rx_done = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0: rx_data = 8'h52;
        1: rx_data = 8'h72;
        2: rx_data = 8'h43;
        3: rx_data = 8'h63;
        4: rx_data = 8'h4D;
        5: rx_data = 8'h6D;
        6: rx_data = 8'h0D;
        7: rx_data = 8'h0A;
        default: rx_data = 8'($urandom);
      endcase
      btn_run   = ($urandom_range(0, 15) == 0);
      btn_clear = ($urandom_range(0, 15) == 0);
      btn_mode  = ($urandom_range(0, 15) == 0);
      tx_busy   = (busy_cnt > 0) || ($urandom_range(0, 7) == 0);
      tick();
      if (tx_start_o) busy_cnt = $urandom_range(2, 5);
      else if (busy_cnt > 0) busy_cnt--;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
